message_gatherer: RTL and testbench

- Receive-side counterpart of the message slicer. Accepts a stream of WIDTH-bit slices, each qualified by in_nd, and reassembles every N_SLICES consecutive slices into one WIDTH*N_SLICES-bit word.
- Sits at the far end of a narrow message link and restores the wide message for downstream blocks.
- A first-slice marker keeps word boundaries aligned. A sticky error flag reports framing faults.

---
 rtl/message_gatherer.sv | 70 +++++++
 tb/tb_message_gatherer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_gatherer.sv
// message_gatherer: reassembles N_SLICES WIDTH-bit slices (first slice in the MSBs) into one word, with a sticky framing-error flag
module message_gatherer #(
  parameter int N_SLICES     = 4,
  parameter int WIDTH        = 32,
  parameter int LOG_N_SLICES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_nd,
  input  logic                      in_first,
  output logic [WIDTH*N_SLICES-1:0] out_data,
  output logic                      out_nd,
  output logic                      error
);
  typedef enum logic {IDLE, COLLECTING} state_t;
  localparam int TOP_LSB = WIDTH * (N_SLICES - 1);
  state_t                    state, next_state;
  logic [LOG_N_SLICES-1:0]   cnt, next_cnt;
  logic [WIDTH*N_SLICES-1:0] asm_word, next_asm;
  logic                      emit, set_err;
  int                        lsb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      asm_word <= '0;
      out_data <= '0;
      out_nd   <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      asm_word <= next_asm;
      out_nd   <= emit;
      error    <= error | set_err;
      if (emit) out_data <= next_asm;
    end
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_asm   = asm_word;
    emit       = 1'b0;
    set_err    = 1'b0;
    lsb        = WIDTH * (N_SLICES - 1 - int'(cnt));
    if (in_nd && in_first) begin
      next_asm[TOP_LSB +: WIDTH] = in_data;
      set_err = (state == COLLECTING);
      if (N_SLICES == 1) begin
        emit       = 1'b1;
        next_cnt   = '0;
        next_state = IDLE;
      end else begin
        next_cnt   = LOG_N_SLICES'(1);
        next_state = COLLECTING;
      end
    end else if (in_nd && state == IDLE) begin
      set_err = 1'b1;
    end else if (in_nd) begin
      next_asm[lsb +: WIDTH] = in_data;
      if (cnt == LOG_N_SLICES'(N_SLICES - 1)) begin
        emit       = 1'b1;
        next_cnt   = '0;
        next_state = IDLE;
      end else begin
        next_cnt = cnt + LOG_N_SLICES'(1);
      end
    end
  end
endmodule

// File: tb/tb_message_gatherer.sv
// tb_message_gatherer: randomized and directed checks against a queue-based reassembly model
module tb_message_gatherer;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_nd = 1'b0;
  logic           in_first = 1'b0;
  logic [W*N-1:0] out_data;
  logic           out_nd;
  logic           error;
  int checks = 0;
  int passes = 0;
  logic [W-1:0]   part[$];
  logic           m_nd = 1'b0;
  logic [W*N-1:0] m_data = '0;
  logic           m_err = 1'b0;

  message_gatherer #(.N_SLICES(N), .WIDTH(W), .LOG_N_SLICES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_first(in_first),
    .out_data(out_data), .out_nd(out_nd), .error(error)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [W-1:0] d, input logic nd, input logic first);
    m_nd = 1'b0;
    if (nd) begin
      if (first) begin
        if (part.size() > 0) m_err = 1'b1;
        part = {};
        part.push_back(d);
      end else if (part.size() == 0) begin
        m_err = 1'b1;
      end else begin
        part.push_back(d);
      end
      if (part.size() == N) begin
        m_data = '0;
        foreach (part[i]) m_data = (m_data << W) | (W*N)'(part[i]);
        m_nd = 1'b1;
        part = {};
      end
    end
  endtask

  task automatic drive(input logic [W-1:0] d, input logic nd, input logic first);
    in_data = d; in_nd = nd; in_first = first;
    @(posedge clk); #1;
    model(d, nd, first);
    in_nd = 1'b0; in_first = 1'b0; in_data = W'($urandom);
  endtask

  task automatic model_reset();
    part = {}; m_nd = 1'b0; m_data = '0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_nd, out_data, error} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL reset: got nd=%b data=%h err=%b want 0/0/0", out_nd, out_data, error);
    else passes++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [7:0] s[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      drive(s[i], 1'b1, i == 0);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL basic[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
    end
    checks++;
    if ({out_nd, out_data, error} !== {1'b1, 32'hA1B2C3D4, 1'b0})
      $display("FAIL basic_word: got nd=%b data=%h err=%b want 1/a1b2c3d4/0", out_nd, out_data, error);
    else passes++;
    drive(8'h00, 1'b0, 1'b0);
    checks++;
    if (out_nd !== 1'b0 || out_data !== 32'hA1B2C3D4)
      $display("FAIL basic_hold: got nd=%b data=%h want 0/a1b2c3d4", out_nd, out_data);
    else passes++;
  endtask

  task automatic test_gapped();
    logic [7:0] s[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < (i == 0 ? 0 : 3); g++) begin
        drive(W'($urandom), 1'b0, 1'($urandom));
        checks++;
        if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
          $display("FAIL gapped_idle[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
        else passes++;
      end
      drive(s[i], 1'b1, i == 0);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL gapped[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
    end
    checks++;
    if ({out_nd, out_data} !== {1'b1, 32'hA1B2C3D4})
      $display("FAIL gapped_word: got nd=%b data=%h want 1/a1b2c3d4", out_nd, out_data);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14};
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(s[i], 1'b1, i % 4 == 0);
      pulses += int'(out_nd);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL b2b[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
      if (i == 5) begin
        checks++;
        if (out_data !== 32'h01020304)
          $display("FAIL b2b_hold: got data=%h want 01020304", out_data);
        else passes++;
      end
    end
    checks++;
    if (pulses != 2 || out_data !== 32'h11121314)
      $display("FAIL b2b_word: got pulses=%0d data=%h want 2/11121314", pulses, out_data);
    else passes++;
  endtask

  task automatic test_misalign();
    logic [7:0] s[6] = '{8'hAA, 8'hBB, 8'h10, 8'h20, 8'h30, 8'h40};
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], 1'b1, i == 0 || i == 2);
      pulses += int'(out_nd);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL misalign[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
    end
    checks++;
    if (pulses != 1 || out_data !== 32'h10203040 || error !== 1'b1)
      $display("FAIL misalign_word: got pulses=%0d data=%h err=%b want 1/10203040/1", pulses, out_data, error);
    else passes++;
  endtask

  task automatic test_orphan();
    drive(8'h55, 1'b1, 1'b0);
    checks++;
    if (error !== 1'b1 || out_nd !== 1'b0)
      $display("FAIL orphan_err: got err=%b nd=%b want 1/0", error, out_nd);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 1), 1'b1, i == 0);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL orphan[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
    end
    checks++;
    if (out_data !== 32'h01020304 || out_nd !== 1'b1)
      $display("FAIL orphan_word: got nd=%b data=%h want 1/01020304", out_nd, out_data);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    drive(8'hA1, 1'b1, 1'b1);
    drive(8'hB2, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_nd, out_data, error} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL reset_async: got nd=%b data=%h err=%b want 0/0/0", out_nd, out_data, error);
    else passes++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'h0A + 8'(i), 1'b1, i == 0);
      pulses += int'(out_nd);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL reset_mid[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
    end
    checks++;
    if (pulses != 1 || out_data !== 32'h0A0B0C0D || error !== 1'b0)
      $display("FAIL reset_mid_word: got pulses=%0d data=%h err=%b want 1/0a0b0c0d/0", pulses, out_data, error);
    else passes++;
  endtask

  task automatic test_random();
    logic nd, first;
    for (int i = 0; i < 400; i++) begin
      nd = ($urandom_range(0, 3) != 0);
      first = (part.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
      drive(W'($urandom), nd, first);
      checks++;
      if ({out_nd, out_data, error} !== {m_nd, m_data, m_err})
        $display("FAIL random[%0d]: got nd=%b data=%h err=%b want nd=%b data=%h err=%b", i, out_nd, out_data, error, m_nd, m_data, m_err);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_misalign();
    test_reset();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
